// File: rtl/wb_arbiter_if.sv
// Writeback bus between the two result sources, the arbiter, the regfile write port
// and the decode-stage pending lookups.
interface wb_arbiter_if;
  logic        flush_i;
  logic        alu_valid;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        lsu_valid;
  logic [4:0]  lsu_addr;
  logic [31:0] lsu_data;
  logic        lsu_ready;
  logic        rd_wren;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        rs1_pend;
  logic        rs2_pend;

  modport slave (
    input  flush_i,
    input  alu_valid, alu_addr, alu_data,
    output alu_ready,
    input  lsu_valid, lsu_addr, lsu_data,
    output lsu_ready,
    output rd_wren, rd_addr, rd_data,
    input  rs1_addr, rs2_addr,
    output rs1_pend, rs2_pend
  );

  modport master (
    output flush_i,
    output alu_valid, alu_addr, alu_data,
    input  alu_ready,
    output lsu_valid, lsu_addr, lsu_data,
    input  lsu_ready,
    input  rd_wren, rd_addr, rd_data,
    output rs1_addr, rs2_addr,
    input  rs1_pend, rs2_pend
  );
endinterface

// File: rtl/wb_arbiter.sv
// Two-source writeback arbiter: per-source FIFOs, round-robin drain into a registered
// regfile write stage, and combinational pending-write lookup for decode.
module wb_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  wb_arbiter_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Source 0 is the ALU, source 1 is the LSU.
  logic        w_in_valid  [2];
  logic [4:0]  w_in_addr   [2];
  logic [31:0] w_in_data   [2];
  logic        w_ready     [2];
  logic        w_nonempty  [2];
  logic        w_grant     [2];
  logic        w_hit1      [2];
  logic        w_hit2      [2];
  logic [4:0]  w_head_addr [2];
  logic [31:0] w_head_data [2];

  logic        w_both;
  logic        w_sel;
  logic        w_win;
  logic        r_last_grant;
  logic        r_rd_wren;
  logic [4:0]  r_rd_addr;
  logic [31:0] r_rd_data;

  assign w_in_valid[0] = bus.alu_valid;
  assign w_in_addr[0]  = bus.alu_addr;
  assign w_in_data[0]  = bus.alu_data;
  assign w_in_valid[1] = bus.lsu_valid;
  assign w_in_addr[1]  = bus.lsu_addr;
  assign w_in_data[1]  = bus.lsu_data;
  assign bus.alu_ready = w_ready[0];
  assign bus.lsu_ready = w_ready[1];

  genvar gi, ei;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      logic [4:0]       r_mem_addr [DEPTH];
      logic [31:0]      r_mem_data [DEPTH];
      logic [PW-1:0]    r_wptr;
      logic [PW-1:0]    r_rptr;
      logic [CW-1:0]    r_cnt;
      logic             w_push;
      logic [DEPTH-1:0] w_valid_mask;
      logic [DEPTH-1:0] w_hit1_vec;
      logic [DEPTH-1:0] w_hit2_vec;

      assign w_ready[gi]     = (r_cnt != CW'(DEPTH));
      assign w_nonempty[gi]  = (r_cnt != '0);
      // Writes to x0 complete the handshake but are never stored.
      assign w_push          = w_in_valid[gi] && w_ready[gi] &&
                               (w_in_addr[gi] != 5'd0) && !bus.flush_i;
      assign w_head_addr[gi] = r_mem_addr[r_rptr];
      assign w_head_data[gi] = r_mem_data[r_rptr];

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          r_wptr <= '0;
          r_rptr <= '0;
          r_cnt  <= '0;
        end else if (bus.flush_i) begin
          r_wptr <= '0;
          r_rptr <= '0;
          r_cnt  <= '0;
        end else begin
          if (w_push)
            r_wptr <= r_wptr + 1'b1;
          if (w_grant[gi])
            r_rptr <= r_rptr + 1'b1;
          if (w_push && !w_grant[gi])
            r_cnt <= r_cnt + 1'b1;
          else if (!w_push && w_grant[gi])
            r_cnt <= r_cnt - 1'b1;
        end
      end

      always_ff @(posedge clk_i) begin
        if (w_push) begin
          r_mem_addr[r_wptr] <= w_in_addr[gi];
          r_mem_data[r_wptr] <= w_in_data[gi];
        end
      end

      // An entry is live when its distance from the read pointer is below the count.
      for (ei = 0; ei < DEPTH; ei++) begin : g_ent
        assign w_valid_mask[ei] = ({1'b0, PW'(ei) - r_rptr} < r_cnt);
        assign w_hit1_vec[ei]   = w_valid_mask[ei] && (r_mem_addr[ei] == bus.rs1_addr);
        assign w_hit2_vec[ei]   = w_valid_mask[ei] && (r_mem_addr[ei] == bus.rs2_addr);
      end

      assign w_hit1[gi] = |w_hit1_vec;
      assign w_hit2[gi] = |w_hit2_vec;
    end
  endgenerate

  assign w_both     = w_nonempty[0] && w_nonempty[1];
  assign w_sel      = w_both ? ~r_last_grant : w_nonempty[1];
  assign w_win      = (w_nonempty[0] || w_nonempty[1]) && !bus.flush_i;
  assign w_grant[0] = w_win && !w_sel;
  assign w_grant[1] = w_win && w_sel;

  // Reset last_grant to the LSU so the ALU takes the first tie.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_last_grant <= 1'b1;
      r_rd_wren    <= 1'b0;
      r_rd_addr    <= 5'd0;
      r_rd_data    <= 32'd0;
    end else begin
      r_rd_wren <= w_win;
      if (w_win) begin
        r_last_grant <= w_sel;
        r_rd_addr    <= w_head_addr[w_sel];
        r_rd_data    <= w_head_data[w_sel];
      end
    end
  end

  assign bus.rd_wren = r_rd_wren;
  assign bus.rd_addr = r_rd_addr;
  assign bus.rd_data = r_rd_data;

  assign bus.rs1_pend = (bus.rs1_addr != 5'd0) &&
                        (w_hit1[0] || w_hit1[1] || (r_rd_wren && (r_rd_addr == bus.rs1_addr)));
  assign bus.rs2_pend = (bus.rs2_addr != 5'd0) &&
                        (w_hit2[0] || w_hit2[1] || (r_rd_wren && (r_rd_addr == bus.rs2_addr)));
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: expected regfile writes are queued at issue time and
// a negedge monitor checks every rd_wren cycle against the queue.
module tb_wb_arbiter;
  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  wb_arbiter_if bus();

  wb_arbiter #(.DEPTH(2)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  int n_pass = 0;
  int n_checks = 0;
  logic [36:0] exp_q[$];
  logic [36:0] mon_e;

  task automatic check(input string name, input logic [36:0] act, input logic [36:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  always @(negedge clk) begin
    if (rst_ni && bus.rd_wren === 1'b1) begin
      $display("write r%0d = 0x%08h", bus.rd_addr, bus.rd_data);
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_write: got r%0d=0x%0h, expected no write", bus.rd_addr, bus.rd_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 37'(bus.rd_addr), 37'(mon_e[36:32]));
        check("wr_data", 37'(bus.rd_data), 37'(mon_e[31:0]));
      end
    end
  end

  task automatic idle();
    bus.flush_i = 1'b0;
    bus.alu_valid = 1'b0; bus.alu_addr = 5'd0; bus.alu_data = 32'd0;
    bus.lsu_valid = 1'b0; bus.lsu_addr = 5'd0; bus.lsu_data = 32'd0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_ni = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0) break;
      step();
    end
    check(name, 37'(exp_q.size()), 37'd0);
    repeat (3) step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int ia, il;
    logic acc_a, acc_l;
    idle();
    bus.rs1_addr = 5'd0;
    bus.rs2_addr = 5'd0;
    #1;
    check("reset_wren", 37'(bus.rd_wren), 37'd0);
    check("reset_addr", 37'(bus.rd_addr), 37'd0);
    check("reset_data", 37'(bus.rd_data), 37'd0);
    check("reset_alu_ready", 37'(bus.alu_ready), 37'd1);
    check("reset_lsu_ready", 37'(bus.lsu_ready), 37'd1);

    // Single ALU write
    do_reset();
    bus.rs1_addr = 5'd3; bus.rs2_addr = 5'd4;
    bus.alu_valid = 1'b1; bus.alu_addr = 5'd3; bus.alu_data = 32'h13579bdf;
    expect_wr(5'd3, 32'h13579bdf);
    check("single_pend_c0", 37'(bus.rs1_pend), 37'd0);
    step(); idle();
    check("single_pend_c1", 37'(bus.rs1_pend), 37'd1);
    check("single_rs2_c1", 37'(bus.rs2_pend), 37'd0);
    check("single_wren_c1", 37'(bus.rd_wren), 37'd0);
    step();
    check("single_pend_c2", 37'(bus.rs1_pend), 37'd1);
    check("single_wren_c2", 37'(bus.rd_wren), 37'd1);
    step();
    check("single_wren_c3", 37'(bus.rd_wren), 37'd0);
    check("single_pend_c3", 37'(bus.rs1_pend), 37'd0);
    drain("single_drain");

    // Tie and alternation
    do_reset();
    bus.alu_valid = 1'b1; bus.alu_addr = 5'd4; bus.alu_data = 32'h1;
    bus.lsu_valid = 1'b1; bus.lsu_addr = 5'd5; bus.lsu_data = 32'hffff1357;
    expect_wr(5'd4, 32'h1); expect_wr(5'd5, 32'hffff1357);
    step();
    bus.alu_addr = 5'd6; bus.alu_data = 32'h246;
    bus.lsu_addr = 5'd7; bus.lsu_data = 32'h1317131f;
    expect_wr(5'd6, 32'h246); expect_wr(5'd7, 32'h1317131f);
    step(); idle();
    for (int c = 2; c < 6; c++) begin
      check($sformatf("tie_wren_c%0d", c), 37'(bus.rd_wren), 37'd1);
      step();
    end
    check("tie_wren_c6", 37'(bus.rd_wren), 37'd0);
    drain("tie_drain");

    // Full and backpressure: both sources push every cycle, grants alternate
    do_reset();
    for (int i = 0; i < 5; i++) begin
      expect_wr(5'(8 + i), 32'ha0000000 + 32'(i));
      expect_wr(5'(16 + i), 32'hb0000000 + 32'(i));
    end
    ia = 0; il = 0;
    for (int k = 0; k < 12; k++) begin
      bus.alu_valid = (ia < 5); bus.alu_addr = 5'(8 + ia);  bus.alu_data = 32'ha0000000 + 32'(ia);
      bus.lsu_valid = (il < 5); bus.lsu_addr = 5'(16 + il); bus.lsu_data = 32'hb0000000 + 32'(il);
      #1;
      if (k == 2) check("alu_ready_c2", 37'(bus.alu_ready), 37'd1);
      if (k == 2) check("lsu_ready_c2", 37'(bus.lsu_ready), 37'd0);
      if (k == 3) check("alu_ready_full_c3", 37'(bus.alu_ready), 37'd0);
      acc_a = bus.alu_valid && bus.alu_ready;
      acc_l = bus.lsu_valid && bus.lsu_ready;
      step();
      if (acc_a) ia++;
      if (acc_l) il++;
    end
    idle();
    check("full_alu_accepts", 37'(ia), 37'd5);
    check("full_lsu_accepts", 37'(il), 37'd5);
    drain("full_drain");

    // x0 discard
    do_reset();
    bus.rs1_addr = 5'd0;
    bus.alu_valid = 1'b1; bus.alu_addr = 5'd0; bus.alu_data = 32'hdeadbeef;
    for (int c = 0; c < 3; c++) begin
      check("x0_alu_ready", 37'(bus.alu_ready), 37'd1);
      check("x0_pend", 37'(bus.rs1_pend), 37'd0);
      step();
    end
    idle();
    for (int c = 0; c < 3; c++) begin
      check("x0_wren", 37'(bus.rd_wren), 37'd0);
      step();
    end
    drain("x0_drain");

    // Flush while the first LSU write sits in the output stage
    do_reset();
    bus.rs1_addr = 5'd9; bus.rs2_addr = 5'd10;
    bus.lsu_valid = 1'b1; bus.lsu_addr = 5'd9; bus.lsu_data = 32'h99;
    expect_wr(5'd9, 32'h99);
    step();
    bus.lsu_addr = 5'd10; bus.lsu_data = 32'haa;
    step();
    idle();
    bus.flush_i = 1'b1;
    bus.alu_valid = 1'b1; bus.alu_addr = 5'd11; bus.alu_data = 32'h11;
    check("flush_wren_c2", 37'(bus.rd_wren), 37'd1);
    check("flush_rs1_pend_c2", 37'(bus.rs1_pend), 37'd1);
    check("flush_rs2_pend_c2", 37'(bus.rs2_pend), 37'd1);
    step(); idle();
    check("flush_wren_c3", 37'(bus.rd_wren), 37'd0);
    check("flush_rs1_pend_c3", 37'(bus.rs1_pend), 37'd0);
    check("flush_rs2_pend_c3", 37'(bus.rs2_pend), 37'd0);
    bus.rs1_addr = 5'd11;
    #1;
    check("flush_alu_dropped_pend", 37'(bus.rs1_pend), 37'd0);
    drain("flush_drain");

    // Asynchronous reset with writes queued and one in the output stage
    do_reset();
    bus.rs1_addr = 5'd13; bus.rs2_addr = 5'd14;
    bus.alu_valid = 1'b1; bus.alu_addr = 5'd12; bus.alu_data = 32'hc;
    bus.lsu_valid = 1'b1; bus.lsu_addr = 5'd13; bus.lsu_data = 32'hd;
    step();
    bus.alu_addr = 5'd14; bus.alu_data = 32'he;
    bus.lsu_valid = 1'b0;
    step(); idle();
    check("mid_wren_before", 37'(bus.rd_wren), 37'd1);
    check("mid_pend_before", 37'(bus.rs2_pend), 37'd1);
    rst_ni = 1'b0;
    #1;
    check("mid_rst_wren", 37'(bus.rd_wren), 37'd0);
    check("mid_rst_addr", 37'(bus.rd_addr), 37'd0);
    check("mid_rst_data", 37'(bus.rd_data), 37'd0);
    check("mid_rst_alu_ready", 37'(bus.alu_ready), 37'd1);
    check("mid_rst_lsu_ready", 37'(bus.lsu_ready), 37'd1);
    check("mid_rst_rs1_pend", 37'(bus.rs1_pend), 37'd0);
    check("mid_rst_rs2_pend", 37'(bus.rs2_pend), 37'd0);
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      check("post_rst_wren", 37'(bus.rd_wren), 37'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
